// File: rtl/reg_file_rename_if.sv
// Issue / ROB / commit bus of the register file with rename table.
// slave = register file side, master = issue/ROB side.
interface reg_file_rename_if #(
    parameter int ROB_W = 4
);
    logic [4:0]       IS_rs1;
    logic [4:0]       IS_rs2;
    logic             IS_rename_sgn;
    logic [4:0]       IS_rd;
    logic             IS_rdy1;
    logic [31:0]      IS_val1;
    logic [ROB_W-1:0] IS_tag1;
    logic             IS_rdy2;
    logic [31:0]      IS_val2;
    logic [ROB_W-1:0] IS_tag2;
    logic [ROB_W-1:0] ROB_ord1;
    logic [ROB_W-1:0] ROB_ord2;
    logic             ROB_rdy1;
    logic [31:0]      ROB_val1;
    logic             ROB_rdy2;
    logic [31:0]      ROB_val2;
    logic [ROB_W-1:0] ROB_new_name;
    logic             CM_sgn;
    logic [4:0]       CM_dest;
    logic [31:0]      CM_value;
    logic [ROB_W-1:0] CM_ROB_name;
    logic             jp_wrong;

    modport slave (
        input  IS_rs1, IS_rs2, IS_rename_sgn, IS_rd,
        output IS_rdy1, IS_val1, IS_tag1,
        output IS_rdy2, IS_val2, IS_tag2,
        output ROB_ord1, ROB_ord2,
        input  ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
        input  ROB_new_name,
        input  CM_sgn, CM_dest, CM_value, CM_ROB_name,
        input  jp_wrong
    );

    modport master (
        output IS_rs1, IS_rs2, IS_rename_sgn, IS_rd,
        input  IS_rdy1, IS_val1, IS_tag1,
        input  IS_rdy2, IS_val2, IS_tag2,
        input  ROB_ord1, ROB_ord2,
        output ROB_rdy1, ROB_val1, ROB_rdy2, ROB_val2,
        output ROB_new_name,
        output CM_sgn, CM_dest, CM_value, CM_ROB_name,
        output jp_wrong
    );
endinterface

// File: rtl/reg_file_rename.sv
// Architectural register file with per-register busy bit and ROB tag.
// Operand lookup bypasses from the commit bus and ROB forwarding ports.
module reg_file_rename #(
    parameter int ROB_W = 4,
    parameter int NREG  = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    reg_file_rename_if.slave    bus
);
    typedef struct packed {
        logic             rdy;
        logic [31:0]      val;
        logic [ROB_W-1:0] tag;
    } opnd_t;

    logic [31:0]      val_q [NREG];
    logic [ROB_W-1:0] tag_q [NREG];
    logic [NREG-1:0]  busy_q;

    opnd_t op1;
    opnd_t op2;

    function automatic opnd_t lookup(
        input logic [4:0]  r,
        input logic        fwd_rdy,
        input logic [31:0] fwd_val
    );
        opnd_t o;
        o.rdy = 1'b1;
        o.val = '0;
        o.tag = '0;
        if (r == 5'd0) begin
            o.rdy = 1'b1;
        end else if (!busy_q[r]) begin
            o.val = val_q[r];
        end else if (bus.CM_sgn &&
                     bus.CM_ROB_name == tag_q[r]) begin
            o.val = bus.CM_value;
        end else if (fwd_rdy) begin
            o.val = fwd_val;
        end else begin
            o.rdy = 1'b0;
            o.tag = tag_q[r];
        end
        return o;
    endfunction

    // Operand 1 lookup against pre-edge state plus same-cycle bypasses.
    always_comb begin
        op1 = lookup(bus.IS_rs1, bus.ROB_rdy1, bus.ROB_val1);
    end

    // Operand 2 lookup against pre-edge state plus same-cycle bypasses.
    always_comb begin
        op2 = lookup(bus.IS_rs2, bus.ROB_rdy2, bus.ROB_val2);
    end

    assign bus.IS_rdy1  = op1.rdy;
    assign bus.IS_val1  = op1.val;
    assign bus.IS_tag1  = op1.tag;
    assign bus.IS_rdy2  = op2.rdy;
    assign bus.IS_val2  = op2.val;
    assign bus.IS_tag2  = op2.tag;
    assign bus.ROB_ord1 = tag_q[bus.IS_rs1];
    assign bus.ROB_ord2 = tag_q[bus.IS_rs2];

    // Commit, rename and flush; later assignments override earlier ones.
    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q <= '0;
            for (int i = 0; i < NREG; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
        end else if (rdy) begin
            if (bus.CM_sgn && bus.CM_dest != 5'd0) begin
                val_q[bus.CM_dest] <= bus.CM_value;
                if (busy_q[bus.CM_dest] &&
                    tag_q[bus.CM_dest] == bus.CM_ROB_name)
                    busy_q[bus.CM_dest] <= 1'b0;
            end
            if (bus.jp_wrong) begin
                busy_q <= '0;
            end else if (bus.IS_rename_sgn &&
                         bus.IS_rd != 5'd0) begin
                busy_q[bus.IS_rd] <= 1'b1;
                tag_q[bus.IS_rd]  <= bus.ROB_new_name;
            end
        end
    end
endmodule
